// File: rtl/wb_host_pkg.sv
// Shared definitions for the Wishbone host master: FSM state encoding,
// default widths and the helpers that derive select and timer widths.
package wb_host_pkg;

   localparam int DEF_ADDR_W  = 32;
   localparam int DEF_DATA_W  = 32;
   localparam int DEF_TIMEOUT = 255;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUS  = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   function automatic int sel_width(input int data_w);
      return data_w / 8;
   endfunction

   // A disabled timeout still needs a one-bit counter to keep the port legal.
   function automatic int timer_width(input int timeout);
      return (timeout < 1) ? 1 : $clog2(timeout + 1);
   endfunction

endpackage

// File: rtl/wb_timeout_ctr.sv
// Saturating cycle counter that flags the last permitted strobe cycle of a
// Wishbone transfer; TIMEOUT of 0 disables expiry entirely.
module wb_timeout_ctr
   import wb_host_pkg::*;
#(
   parameter int TIMEOUT = DEF_TIMEOUT,
   parameter int CNT_W   = timer_width(TIMEOUT)
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expire
);

   localparam logic [CNT_W-1:0] LAST    = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [CNT_W-1:0] count;

   // Saturation only matters when expiry is disabled and a slave stalls forever.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable && (count != CNT_MAX)) begin
         count <= count + 1'b1;
      end
   end

   assign expire = (TIMEOUT != 0) && (count == LAST);

endmodule

// File: rtl/wb_host_master.sv
// Wishbone classic initiator: one single-beat read or write per command,
// answered on a valid/ready response port with read data or a timeout error.
module wb_host_master
   import wb_host_pkg::*;
#(
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter int DATA_W  = DEF_DATA_W,
   parameter int TIMEOUT = DEF_TIMEOUT,
   parameter int SEL_W   = sel_width(DATA_W)
) (
   input  logic              wb_clk_i,
   input  logic              wb_rst_i,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_we,
   input  logic [ADDR_W-1:0] cmd_adr,
   input  logic [DATA_W-1:0] cmd_dat,
   input  logic [SEL_W-1:0]  cmd_sel,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_dat,
   output logic              rsp_err,
   output logic              busy,
   output logic              wbm_cyc_o,
   output logic              wbm_stb_o,
   output logic              wbm_we_o,
   output logic [SEL_W-1:0]  wbm_sel_o,
   output logic [ADDR_W-1:0] wbm_adr_o,
   output logic [DATA_W-1:0] wbm_dat_o,
   input  logic [DATA_W-1:0] wbm_dat_i,
   input  logic              wbm_ack_i
);

   state_t state;
   state_t next_state;

   logic load_cmd;
   logic finish_ok;
   logic finish_err;
   logic timer_clear;
   logic timer_en;
   logic expire;

   wb_timeout_ctr #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout (
      .clk    (wb_clk_i),
      .rst    (wb_rst_i),
      .clear  (timer_clear),
      .enable (timer_en),
      .expire (expire)
   );

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state <= ST_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Ack is tested before expiry so a slave answering on the final cycle wins.
   always_comb begin
      next_state  = state;
      load_cmd    = 1'b0;
      finish_ok   = 1'b0;
      finish_err  = 1'b0;
      timer_clear = 1'b0;
      timer_en    = 1'b0;
      case (state)
         ST_IDLE: begin
            timer_clear = 1'b1;
            if (cmd_valid) begin
               load_cmd   = 1'b1;
               next_state = ST_BUS;
            end
         end
         ST_BUS: begin
            if (wbm_ack_i) begin
               finish_ok  = 1'b1;
               next_state = ST_RESP;
            end else if (expire) begin
               finish_err = 1'b1;
               next_state = ST_RESP;
            end else begin
               timer_en = 1'b1;
            end
         end
         ST_RESP: begin
            if (rsp_ready) begin
               next_state = ST_IDLE;
            end
         end
         default: begin
            next_state = ST_IDLE;
         end
      endcase
   end

   // Address, data and select keep their last value after the cycle ends.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         wbm_we_o  <= 1'b0;
         wbm_sel_o <= '0;
         wbm_adr_o <= '0;
         wbm_dat_o <= '0;
      end else if (load_cmd) begin
         wbm_we_o  <= cmd_we;
         wbm_sel_o <= cmd_sel;
         wbm_adr_o <= cmd_adr;
         wbm_dat_o <= cmd_dat;
      end
   end

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         rsp_dat <= '0;
         rsp_err <= 1'b0;
      end else if (finish_ok) begin
         rsp_dat <= wbm_we_o ? '0 : wbm_dat_i;
         rsp_err <= 1'b0;
      end else if (finish_err) begin
         rsp_dat <= '0;
         rsp_err <= 1'b1;
      end
   end

   // Deriving cyc from the state register lets an async reset drop it at once.
   assign wbm_cyc_o = (state == ST_BUS);
   assign wbm_stb_o = wbm_cyc_o;
   assign cmd_ready = (state == ST_IDLE);
   assign rsp_valid = (state == ST_RESP);
   assign busy      = (state != ST_IDLE);

endmodule
